card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 194 +++++++++++++++++++
 tb/tb_card_dealer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Texas hold'em card dealer: draws unique cards from a free-running PRNG per betting round.
// Define DEALER_BURN_EN to burn one card before the flop, turn and river.
module card_dealer #(
    parameter int unsigned MAX_RETRY = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       deal_start,
    input  logic [2:0] round,
    input  logic [5:0] rnd,
    output logic       busy,
    output logic       card_valid,
    output logic [5:0] card,
    output logic [3:0] rank,
    output logic [1:0] suit,
    output logic [3:0] slot,
    output logic       deal_done,
    output logic       seq_err,
    output logic       deal_err
);

    localparam int unsigned NUM_CARDS = 52;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE, S_ERR} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             exp_q, exp_d;
    logic [2:0]             round_q, round_d;
    logic [NUM_CARDS-1:0]   used_q, used_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [2:0]             left_q, left_d;
    logic [3:0]             slot_nxt_q, slot_nxt_d;
    logic                   burn_q, burn_d;
    logic                   busy_q, busy_d;
    logic                   card_valid_q, card_valid_d;
    logic [5:0]             card_q, card_d;
    logic [3:0]             slot_q, slot_d;
    logic                   deal_done_q, deal_done_d;
    logic                   seq_err_q, seq_err_d;
    logic                   deal_err_q, deal_err_d;

    logic start_ok;
    logic start_bad;
    logic rnd_ok;
    logic retry_full;

    // Tallyup is always legal; from ERR it is the only way out.
    assign start_ok   = deal_start && !busy_q &&
                        (((state_q == S_IDLE) && ((round == exp_q) || (round == 3'd4))) ||
                         ((state_q == S_ERR) && (round == 3'd4)));
    assign start_bad  = deal_start && !busy_q && (state_q == S_IDLE) && !start_ok;
    assign rnd_ok     = (rnd < 6'(NUM_CARDS)) && !used_q[rnd];
    assign retry_full = (retry_q == RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_ok) state_d = (round == 3'd4) ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                if (rnd_ok) begin
                    if (!burn_q && (left_q == 3'd1)) state_d = S_DONE;
                end else if (retry_full) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        exp_d        = exp_q;
        round_d      = round_q;
        used_d       = used_q;
        retry_d      = retry_q;
        left_d       = left_q;
        slot_nxt_d   = slot_nxt_q;
        burn_d       = burn_q;
        busy_d       = busy_q;
        card_valid_d = 1'b0;
        card_d       = card_q;
        slot_d       = slot_q;
        deal_done_d  = 1'b0;
        seq_err_d    = 1'b0;
        deal_err_d   = deal_err_q;

        // busy covers the deal_done cycle and drops one cycle later
        if (deal_done_q) busy_d = 1'b0;
        if (start_bad)   seq_err_d = 1'b1;

        if (start_ok) begin
            busy_d  = 1'b1;
            round_d = round;
            retry_d = '0;
            case (round)
                3'd0:    begin left_d = 3'd4; slot_nxt_d = 4'd0; end
                3'd1:    begin left_d = 3'd3; slot_nxt_d = 4'd4; end
                3'd2:    begin left_d = 3'd1; slot_nxt_d = 4'd7; end
                3'd3:    begin left_d = 3'd1; slot_nxt_d = 4'd8; end
                default: begin left_d = 3'd0; slot_nxt_d = slot_nxt_q; end
            endcase
`ifdef DEALER_BURN_EN
            burn_d = (round == 3'd1) || (round == 3'd2) || (round == 3'd3);
`else
            burn_d = 1'b0;
`endif
            if (round == 3'd4) begin
                used_d     = '0;
                deal_err_d = 1'b0;
            end
        end

        case (state_q)
            S_DRAW: begin
                if (rnd_ok) begin
                    used_d[rnd] = 1'b1;
                    retry_d     = '0;
                    if (burn_q) begin
                        burn_d = 1'b0;
                    end else begin
                        card_valid_d = 1'b1;
                        card_d       = rnd;
                        slot_d       = slot_nxt_q;
                        slot_nxt_d   = slot_nxt_q + 4'd1;
                        left_d       = left_q - 3'd1;
                    end
                end else if (retry_full) begin
                    deal_err_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            S_DONE: begin
                deal_done_d = 1'b1;
                exp_d       = (round_q == 3'd4) ? 3'd0 : round_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q        <= '0;
            round_q      <= '0;
            used_q       <= '0;
            retry_q      <= '0;
            left_q       <= '0;
            slot_nxt_q   <= '0;
            burn_q       <= 1'b0;
            busy_q       <= 1'b0;
            card_valid_q <= 1'b0;
            card_q       <= '0;
            slot_q       <= '0;
            deal_done_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            deal_err_q   <= 1'b0;
        end else begin
            exp_q        <= exp_d;
            round_q      <= round_d;
            used_q       <= used_d;
            retry_q      <= retry_d;
            left_q       <= left_d;
            slot_nxt_q   <= slot_nxt_d;
            burn_q       <= burn_d;
            busy_q       <= busy_d;
            card_valid_q <= card_valid_d;
            card_q       <= card_d;
            slot_q       <= slot_d;
            deal_done_q  <= deal_done_d;
            seq_err_q    <= seq_err_d;
            deal_err_q   <= deal_err_d;
        end
    end

    assign busy       = busy_q;
    assign card_valid = card_valid_q;
    assign card       = card_q;
    assign slot       = slot_q;
    assign deal_done  = deal_done_q;
    assign seq_err    = seq_err_q;
    assign deal_err   = deal_err_q;
    assign rank       = 4'(card_q % 6'd13);
    assign suit       = 2'(card_q / 6'd13);

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer against a deck/rules reference model.
module tb_card_dealer;

    localparam int MAX_RETRY = 63;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       deal_start = 1'b0;
    logic [2:0] round = 3'd0;
    logic [5:0] rnd = 6'd0;
    logic       busy, card_valid, deal_done, seq_err, deal_err;
    logic [5:0] card;
    logic [3:0] rank, slot;
    logic [1:0] suit;

    card_dealer #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .deal_start(deal_start), .round(round), .rnd(rnd),
        .busy(busy), .card_valid(card_valid), .card(card), .rank(rank), .suit(suit),
        .slot(slot), .deal_done(deal_done), .seq_err(seq_err), .deal_err(deal_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_used[52];
    int m_exp  = 0;
    bit m_err  = 1'b0;
    int m_card = 0;
    int m_slot = 0;
    int rq[$];
    int dealt[$];

`ifdef DEALER_BURN_EN
    localparam bit BURN = 1'b1;
`else
    localparam bit BURN = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int next_rnd();
        if (rq.size() > 0) return rq.pop_front();
        return int'($urandom_range(0, 63));
    endfunction

    function automatic int n_cards(input int r);
        case (r)
            0: return 4;
            1: return 3;
            2: return 1;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int first_slot(input int r);
        case (r)
            0: return 0;
            1: return 4;
            2: return 7;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_exp = 0; m_err = 1'b0; m_card = 0; m_slot = 0;
        dealt.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_card_valid"}, card_valid, 0);
        check({tag, "_card"}, card, 0);
        check({tag, "_rank"}, rank, 0);
        check({tag, "_suit"}, suit, 0);
        check({tag, "_slot"}, slot, 0);
        check({tag, "_deal_done"}, deal_done, 0);
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_deal_err"}, deal_err, 0);
    endtask

    // Issue one deal_start and follow it to completion; abort_after>0 resets after that many cards.
    task automatic deal(input int r, input int abort_after);
        bit legal, burn, acc, exp_cv;
        int left, nslot, retry, cur, got_cards;
        @(negedge clk);
        round = 3'(r);
        deal_start = 1'b1;
        legal = (r == 4) || (!m_err && r == m_exp);
        @(negedge clk);
        deal_start = 1'b0;
        if (!legal) begin
            check("seq_err", seq_err, m_err ? 0 : 1);
            check("rej_busy", busy, 0);
            @(negedge clk);
            check("seq_err_pulse", seq_err, 0);
            check("rej_busy2", busy, 0);
            check("rej_no_card", card_valid, 0);
            return;
        end
        check("busy_rise", busy, 1);
        check("acc_seq_err", seq_err, 0);
        if (r == 4) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_err = 1'b0; m_exp = 0;
            dealt.delete();
            check("tally_err_clr", deal_err, 0);
            @(negedge clk);
            check("tally_done", deal_done, 1);
            check("tally_busy", busy, 1);
            @(negedge clk);
            check("tally_done_pulse", deal_done, 0);
            check("tally_busy_fall", busy, 0);
            return;
        end
        left = n_cards(r);
        nslot = first_slot(r);
        burn = BURN && (r >= 1);
        retry = 0;
        got_cards = 0;
        cur = next_rnd();
        rnd = 6'(cur);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            acc = (cur < 52) && !m_used[cur];
            exp_cv = 1'b0;
            if (acc) begin
                m_used[cur] = 1'b1;
                retry = 0;
                if (burn) burn = 1'b0;
                else begin
                    exp_cv = 1'b1; m_card = cur; m_slot = nslot; nslot++; left--;
                end
            end else begin
                retry++;
            end
            check("card_valid", card_valid, exp_cv);
            check("card", card, m_card);
            check("slot", slot, m_slot);
            check("rank", rank, m_card % 13);
            check("suit", suit, m_card / 13);
            check("busy_seq_err", seq_err, 0);
            check("early_done", deal_done, 0);
            if (card_valid) begin
                dealt.push_back(int'(card));
                got_cards++;
            end
            if (retry == MAX_RETRY + 1) begin
                deal_start = 1'b0;
                m_err = 1'b1;
                check("deal_err", deal_err, 1);
                check("err_busy", busy, 0);
                @(negedge clk);
                check("err_no_done", deal_done, 0);
                check("err_sticky", deal_err, 1);
                return;
            end
            if (abort_after > 0 && got_cards == abort_after) begin
                rst_n = 1'b0;
                deal_start = 1'b0;
                #1;
                check_all_zero("abort");
                model_reset();
                @(negedge clk);
                check("abort_hold_cv", card_valid, 0);
                rst_n = 1'b1;
                return;
            end
            if (left == 0) begin
                deal_start = 1'b0;
                @(negedge clk);
                check("deal_done", deal_done, 1);
                check("done_busy", busy, 1);
                check("done_no_card", card_valid, 0);
                m_exp = r + 1;
                @(negedge clk);
                check("done_pulse", deal_done, 0);
                check("busy_fall", busy, 0);
                return;
            end
            // deal_start while busy must be ignored
            deal_start = ($urandom_range(0, 3) == 0);
            round = 3'($urandom_range(0, 7));
            cur = next_rnd();
            rnd = 6'(cur);
        end
        check("draw_timeout", left, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp34[4];
        int save[$];
        int nd;
        bit seen[52];
        exp34 = '{5, 7, 8, 9};
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // fixed preflop: duplicate and out-of-range draws rejected
        rq = '{5, 5, 60, 7, 8, 9};
        deal(0, 0);
        check("pf_count", dealt.size(), 4);
        for (int i = 0; i < 4 && i < dealt.size(); i++) check("pf_card", dealt[i], exp34[i]);

        // out-of-order turn, then flop proves exp still 1
        deal(2, 0);
        rq = '{51};
        deal(1, 0);
        deal(2, 0);
        deal(3, 0);
        check("full_count", dealt.size(), 9);
        nd = 0;
        foreach (dealt[i]) if (dealt[i] < 52 && !seen[dealt[i]]) begin seen[dealt[i]] = 1'b1; nd++; end
        check("distinct", nd, 9);

        deal(4, 0);
        deal(3, 0);
        deal(0, 0);
        save = dealt;

        // retry exhaustion, ignored starts in ERR, tallyup recovery
        rq.delete();
        repeat (64) rq.push_back(63);
        deal(1, 0);
        deal(2, 0);
        deal(0, 0);
        deal(4, 0);
        rq = save;
        deal(0, 0);
        check("reuse_count", dealt.size(), save.size());
        for (int i = 0; i < dealt.size() && i < save.size(); i++) check("reuse_card", dealt[i], save[i]);

        // reset between 2nd and 3rd flop card
        deal(1, 2);
        deal(0, 0);
        deal(1, 0);

`ifdef DEALER_BURN_EN
        deal(2, 0); deal(3, 0); deal(4, 0);
        rq = '{20, 21, 22, 23};
        deal(0, 0);
        rq = '{10, 11, 12, 13};
        deal(1, 0);
        check("burn_flop_n", dealt.size(), 7);
        if (dealt.size() == 7) begin
            check("burn_c0", dealt[4], 11);
            check("burn_c1", dealt[5], 12);
            check("burn_c2", dealt[6], 13);
        end
        rq = '{10, 30, 31};
        deal(2, 0);
        check("burn_turn", dealt[dealt.size() - 1], 31);
`endif

        for (int it = 0; it < 40; it++) begin
            int r;
            if ($urandom_range(0, 4) == 0) r = int'($urandom_range(0, 7));
            else r = m_err ? 4 : m_exp;
            deal(r, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
